// File: rtl/seq_generator.sv
// Serial pattern transmitter: sends a SEQ_W-bit pattern MSB-first, repeated
// a latched number of times, with optional fill-bit gaps between repetitions.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for start_i; outputs quiet, sent_cnt_o holds
// SEND  | shifting pattern bits out, one per clock
// GAP   | driving fill bits between repetitions
// DONE  | one-cycle done_o pulse, then back to IDLE
module seq_generator #(
    parameter int SEQ_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [SEQ_W-1:0] ref_i,
    input  logic [CNT_W-1:0] reps_i,
    input  logic [GAP_W-1:0] gap_i,
    input  logic             fill_i,
    output logic             ready_o,
    output logic             bit_o,
    output logic             bit_vld_o,
    output logic             last_o,
    output logic             done_o,
    output logic [CNT_W-1:0] sent_cnt_o
);

    localparam int IDX_W = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEQ_W-1:0]   r_ref;
    logic [SEQ_W-1:0]   r_shift;
    logic [CNT_W-1:0]   r_reps;
    logic [GAP_W-1:0]   r_gap;
    logic               r_fill;
    logic [IDX_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [CNT_W-1:0]   r_sent_cnt;
    logic               w_accept;
    logic               w_pat_end;
    logic               w_last_rep;

    // r_bit_cnt counts down to the final pattern bit; r_sent_cnt doubles as the
    // repetition counter, so the last repetition is the one about to complete r_reps.
    assign w_pat_end  = (r_bit_cnt == '0);
    assign w_last_rep = ((r_sent_cnt + CNT_W'(1)) == r_reps);
    assign sent_cnt_o = r_sent_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        ready_o     = 1'b0;
        bit_o       = 1'b0;
        bit_vld_o   = 1'b0;
        last_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (reps_i != '0) ? S_SEND : S_DONE;
                end
            end
            S_SEND: begin
                bit_vld_o = 1'b1;
                bit_o     = r_shift[SEQ_W-1];
                last_o    = w_pat_end && w_last_rep;
                if (w_pat_end) begin
                    if (w_last_rep)
                        w_state_nxt = S_DONE;
                    else if (r_gap != '0)
                        w_state_nxt = S_GAP;
                    else
                        w_state_nxt = S_SEND;
                end
            end
            S_GAP: begin
                bit_vld_o = 1'b1;
                bit_o     = r_fill;
                if (r_gap_cnt == '0)
                    w_state_nxt = S_SEND;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort_i && (r_state != S_IDLE))
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_ref      <= '0;
            r_shift    <= '0;
            r_reps     <= '0;
            r_gap      <= '0;
            r_fill     <= 1'b0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_sent_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ref      <= ref_i;
                r_shift    <= ref_i;
                r_reps     <= reps_i;
                r_gap      <= gap_i;
                r_fill     <= fill_i;
                r_bit_cnt  <= LAST_IDX;
                r_sent_cnt <= '0;
            end else if (!abort_i) begin
                case (r_state)
                    S_SEND: begin
                        if (w_pat_end) begin
                            r_bit_cnt  <= LAST_IDX;
                            r_shift    <= r_ref;
                            r_sent_cnt <= r_sent_cnt + CNT_W'(1);
                            // preloaded every repetition; only consumed when a gap follows
                            r_gap_cnt  <= r_gap - GAP_W'(1);
                        end else begin
                            r_bit_cnt <= r_bit_cnt - IDX_W'(1);
                            r_shift   <= {r_shift[SEQ_W-2:0], 1'b0};
                        end
                    end
                    S_GAP:   r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: table of transmissions with hand-computed
// bit streams, plus abort, reset and busy-start sequences.
module tb_seq_generator;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [3:0] ref_i = '0;
    logic [3:0] reps_i = '0;
    logic [3:0] gap_i = '0;
    logic       fill_i = 1'b0;
    logic       ready_o;
    logic       bit_o;
    logic       bit_vld_o;
    logic       last_o;
    logic       done_o;
    logic [3:0] sent_cnt_o;

    seq_generator #(.SEQ_W(4), .CNT_W(4), .GAP_W(4)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .ref_i      (ref_i),
        .reps_i     (reps_i),
        .gap_i      (gap_i),
        .fill_i     (fill_i),
        .ready_o    (ready_o),
        .bit_o      (bit_o),
        .bit_vld_o  (bit_vld_o),
        .last_o     (last_o),
        .done_o     (done_o),
        .sent_cnt_o (sent_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]  rf;
        logic [3:0]  rp;
        logic [3:0]  gp;
        logic        fl;
        int          len;
        logic [63:0] bits;
        logic [3:0]  sent;
    } vec_t;

    vec_t tbl [8];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle, or of the
    // cycle after a kill (abort or reset) has been applied.
    task automatic run_txn(input logic [3:0] rf, input logic [3:0] rp, input logic [3:0] gp,
                           input logic fl, input int poke_at, input int kill_at, input bit kill_rst,
                           output logic [63:0] bits, output int len, output int first_cyc,
                           output int done_cyc, output int last_cnt, output int last_pos,
                           output int quiet_bad);
        ref_i = rf; reps_i = rp; gap_i = gp; fill_i = fl; start_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0; abort_i = 1'b0;
        ref_i = ~rf; reps_i = ~rp; gap_i = ~gp; fill_i = ~fl;
        bits = '0; len = 0; first_cyc = -1; done_cyc = -1;
        last_cnt = 0; last_pos = 0; quiet_bad = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            start_i = 1'b0;
            if (bit_vld_o) begin
                bits = {bits[62:0], bit_o};
                len++;
                if (first_cyc < 0) first_cyc = cyc;
                if (last_o) begin last_cnt++; last_pos = len; end
            end else if (bit_o || last_o) begin
                quiet_bad++;
            end
            if (done_o) begin done_cyc = cyc; break; end
            if (poke_at != 0 && bit_vld_o && len == poke_at) begin
                start_i = 1'b1; ref_i = 4'b1111; reps_i = 4'd1;
            end
            if (kill_at != 0 && bit_vld_o && len == kill_at) begin
                if (kill_rst) rst_i = 1'b1; else abort_i = 1'b1;
                @(posedge clk_i);
                @(negedge clk_i);
                rst_i = 1'b0; abort_i = 1'b0;
                break;
            end
            @(posedge clk_i);
            @(negedge clk_i);
        end
        start_i = 1'b0;
    endtask

    initial begin
        logic [63:0] bits;
        int len, first_cyc, done_cyc, last_cnt, last_pos, quiet_bad, pulses;

        tbl[0] = '{4'b1011, 4'd1,  4'd0,  1'b0, 4,  64'b1011, 4'd1};
        tbl[1] = '{4'b1011, 4'd3,  4'd2,  1'b0, 16, 64'b1011_00_1011_00_1011, 4'd3};
        tbl[2] = '{4'b1011, 4'd0,  4'd2,  1'b1, 0,  64'd0, 4'd0};
        tbl[3] = '{4'b0110, 4'd2,  4'd0,  1'b1, 8,  64'b0110_0110, 4'd2};
        tbl[4] = '{4'b1001, 4'd2,  4'd1,  1'b1, 9,  64'b1001_1_1001, 4'd2};
        tbl[5] = '{4'b1001, 4'd5,  4'd3,  1'b0, 32, 64'h9122_4489, 4'd5};
        tbl[6] = '{4'b1100, 4'd2,  4'd15, 1'b1, 23, 64'b1100_111111111111111_1100, 4'd2};
        tbl[7] = '{4'b1010, 4'd15, 4'd0,  1'b0, 60, 64'h0AAA_AAAA_AAAA_AAAA, 4'd15};

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready",  64'(ready_o), 64'd1);
        chk("rst_quiet",  64'({bit_o, bit_vld_o, last_o, done_o}), 64'd0);
        chk("rst_sent",   64'(sent_cnt_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 8; i++) begin
            if (i == 3) abort_i = 1'b1;  // start and abort together in IDLE
            run_txn(tbl[i].rf, tbl[i].rp, tbl[i].gp, tbl[i].fl, 0, 0, 1'b0,
                    bits, len, first_cyc, done_cyc, last_cnt, last_pos, quiet_bad);
            chk($sformatf("v%0d_bits", i), bits, tbl[i].bits);
            chk($sformatf("v%0d_len", i), 64'(len), 64'(tbl[i].len));
            chk($sformatf("v%0d_first", i), 64'(first_cyc), 64'((tbl[i].len > 0) ? 1 : -1));
            chk($sformatf("v%0d_done_cyc", i), 64'(done_cyc), 64'(tbl[i].len + 1));
            chk($sformatf("v%0d_last_cnt", i), 64'(last_cnt), 64'((tbl[i].len > 0) ? 1 : 0));
            chk($sformatf("v%0d_last_pos", i), 64'(last_pos), 64'(tbl[i].len));
            chk($sformatf("v%0d_quiet", i), 64'(quiet_bad), 64'd0);
            chk($sformatf("v%0d_sent", i), 64'(sent_cnt_o), 64'(tbl[i].sent));
            @(negedge clk_i);
            chk($sformatf("v%0d_ready_after", i), 64'({ready_o, done_o}), 64'b10);
            chk($sformatf("v%0d_sent_hold", i), 64'(sent_cnt_o), 64'(tbl[i].sent));
        end

        // abort alone in IDLE does nothing
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("idle_abort_ready", 64'(ready_o), 64'd1);
        chk("idle_abort_sent", 64'(sent_cnt_o), 64'd15);

        // abort on the 7th valid bit: 0110 0 01
        run_txn(4'b0110, 4'd4, 4'd1, 1'b0, 0, 7, 1'b0,
                bits, len, first_cyc, done_cyc, last_cnt, last_pos, quiet_bad);
        chk("abort_bits", bits, 64'b0110_0_01);
        chk("abort_idle", 64'({ready_o, bit_vld_o, bit_o, done_o}), 64'b1000);
        chk("abort_sent", 64'(sent_cnt_o), 64'd1);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (done_o || bit_vld_o) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);

        // start with ref=1111 during SEND is ignored
        run_txn(4'b1011, 4'd2, 4'd0, 1'b0, 2, 0, 1'b0,
                bits, len, first_cyc, done_cyc, last_cnt, last_pos, quiet_bad);
        chk("busy_start_bits", bits, 64'b1011_1011);
        chk("busy_start_done", 64'(done_cyc), 64'd9);
        chk("busy_start_sent", 64'(sent_cnt_o), 64'd2);
        @(negedge clk_i);

        // reset during the first gap bit
        run_txn(4'b1011, 4'd3, 4'd2, 1'b1, 0, 5, 1'b1,
                bits, len, first_cyc, done_cyc, last_cnt, last_pos, quiet_bad);
        chk("rst_gap_bits", bits, 64'b1011_1);
        chk("rst_gap_ready", 64'(ready_o), 64'd1);
        chk("rst_gap_quiet", 64'({bit_o, bit_vld_o, last_o, done_o}), 64'd0);
        chk("rst_gap_sent", 64'(sent_cnt_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
